// File: rtl/ms_timer_scheduler.sv
// Shared 1 ms countdown timer, round-robin arbitrated among 4 level-sensitive requesters.
// Latency: grant registers 1 edge after req; done pulses N*CLK_PER_MS cycles after grant rises (2 cycles for N=0).
// Backpressure: requesters hold req until done; dropping req while owning the timer aborts without a done pulse.
module ms_timer_scheduler #(
  parameter int CLK_PER_MS = 100000,
  parameter int DUR_W      = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [3:0]         i_req,
  input  logic [4*DUR_W-1:0] i_dur,
  output logic [3:0]         o_grant,
  output logic [3:0]         o_done,
  output logic               o_busy,
  output logic [DUR_W-1:0]   o_remaining,
  output logic               o_tick_ms
);

  localparam int PW = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [3:0]       r_grant;
  logic [3:0]       r_done;
  logic             r_busy;
  logic [DUR_W-1:0] r_remaining;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  // High only in the first RUN cycle, so a zero duration completes one cycle later.
  logic             r_first;

  logic             w_tick;
  logic             w_any;
  logic             w_enter_run;
  logic             w_owner_req;
  logic [1:0]       w_win_idx;
  logic [DUR_W-1:0] w_win_dur;

  assign w_tick      = (r_presc == PS_MAX);
  assign w_any       = |i_req;
  assign w_enter_run = (r_state == S_IDLE) && w_any;
  assign w_owner_req = |(i_req & r_grant);
  assign w_win_dur   = i_dur[w_win_idx*DUR_W +: DUR_W];

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_remaining = r_remaining;
  assign o_tick_ms   = w_tick;

  // Round-robin pick: search starts at last+1; descending loop lets the nearest hit win.
  always_comb begin
    w_win_idx = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (i_req[2'(r_last + 2'(k))]) begin
        w_win_idx = 2'(r_last + 2'(k));
      end
    end
  end

  // Free-running 1 ms prescaler, realigned to zero whenever a countdown starts.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
    end else if (w_enter_run || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Arbitration and countdown FSM with registered grant/done/busy/remaining.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_remaining <= '0;
      r_last      <= 2'd3;
      r_owner     <= 2'd0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_any) begin
            r_state     <= S_RUN;
            r_owner     <= w_win_idx;
            r_grant     <= 4'b0001 << w_win_idx;
            r_remaining <= w_win_dur;
            r_busy      <= 1'b1;
            r_first     <= 1'b1;
          end
        end

        S_RUN: begin
          r_first <= 1'b0;
          if (!w_owner_req) begin
            // Abort wins over a coinciding final tick: no done pulse.
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_last      <= r_owner;
          end else if (r_remaining == '0) begin
            if (!r_first) begin
              r_state <= S_DONE;
              r_done  <= r_grant;
            end
          end else if (w_tick) begin
            if (r_remaining == DUR_W'(1)) begin
              r_remaining <= '0;
              r_state     <= S_DONE;
              r_done      <= r_grant;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_owner;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ms_timer_scheduler.md
MS_TIMER_SCHEDULER -- requirements
Module: ms_timer_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_PER_MS, default 100000, meaning clock cycles per 1 ms tick; legal values are 2 or greater.
REQ-002 The block SHALL have parameter DUR_W, default 16, meaning the width of a duration in ms.
REQ-003 clock  input  1  100 MHz system clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 req  input  4  per-requester timer request, level-sensitive, held until done.
REQ-006 dur  input  4*DUR_W  requested duration in ms; requester i uses bits [i*DUR_W +: DUR_W].
REQ-007 grant  output  4  one-hot owner of the shared timer; all zero when idle.
REQ-008 done  output  4  one-cycle pulse to the requester whose timer expired.
REQ-009 busy  output  1  high while the state is RUN or DONE.
REQ-010 remaining  output  DUR_W  ms left in the active countdown.
REQ-011 tick_ms  output  1  one-cycle 1 ms tick pulse from the internal prescaler.

Function
REQ-012 The 1 ms base SHALL be a prescaler counter with an enable pulse, not a derived clock; no logic SHALL be clocked by anything other than clock.
REQ-013 The prescaler SHALL count 0..CLK_PER_MS-1 and wrap to 0; tick_ms SHALL be high exactly in the cycle the count equals CLK_PER_MS-1.
REQ-014 The prescaler SHALL be forced to 0 in the cycle the FSM enters RUN; outside that event it SHALL run freely in all states.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE, no req bit set: the FSM SHALL stay in IDLE.
REQ-017 IDLE, any req bit set: the FSM SHALL select a winner by round-robin, starting the search at (last+1) mod 4, where last is the previous winner.
REQ-018 The FSM SHALL register grant to the winner, load remaining from that requester's dur field, and move to RUN on the next edge; grant SHALL NOT appear in the same cycle as req (latency 1).
REQ-019 If the loaded duration is 0, the FSM SHALL go to DONE in the cycle after RUN is entered, without waiting for a tick.
REQ-020 RUN, tick_ms high, remaining > 1: remaining SHALL decrement by 1.
REQ-021 RUN, tick_ms high, remaining == 1: remaining SHALL become 0 and the FSM SHALL move to DONE.
REQ-022 The first tick SHALL occur CLK_PER_MS cycles after grant rises, so a duration of N gives DONE exactly N*CLK_PER_MS cycles after grant rises.
REQ-023 DONE SHALL last one cycle, with done = grant during that cycle, then clear grant, set last = winner, and return to IDLE.
REQ-024 A new arbitration SHALL be possible in the cycle after DONE.
REQ-025 Abort: if the granted requester drops req during RUN, the FSM SHALL return to IDLE on the next edge, with no done pulse, grant cleared, remaining cleared to 0, and last = that requester.
REQ-026 If abort (REQ-025) and the final tick (REQ-021) happen in the same cycle, abort SHALL take priority.
REQ-027 req changes by non-owners during RUN or DONE SHALL have no effect until IDLE.
REQ-028 dur SHALL be sampled only at grant; later changes to dur SHALL NOT affect the active countdown.
REQ-029 grant and done SHALL always be one-hot or zero; done SHALL never be set without the matching grant bit.
REQ-030 remaining SHALL never underflow below 0.

Reset
REQ-031 While reset_n is low, the block SHALL hold: state IDLE, grant=0, done=0, busy=0, remaining=0, tick_ms=0, prescaler=0, last=3 (so requester 0 has first priority).
REQ-032 Reset asserted mid-RUN SHALL abort immediately with no done pulse.
REQ-033 After reset_n rises, the first arbitration SHALL take place on the first clock edge.

Verification (CLK_PER_MS=4, DUR_W=8)
REQ-034 Single request: req=0001, dur0=3 -> grant=0001 one cycle later, remaining steps 3,2,1,0, done=0001 pulse exactly 12 cycles after grant rises, then grant=0.
REQ-035 Round-robin: req=1111 held with all dur=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each followed by a done pulse.
REQ-036 Zero duration: req=0100, dur2=0 -> grant=0100, done=0100 two cycles after grant rises, with no tick consumed.
REQ-037 Abort: req=0010, dur1=5, drop req1 after 6 cycles -> grant=0 next cycle, no done pulse, and the next req=0011 grants 0100-side-first order, i.e. grant=0001.
REQ-038 Reset mid-run: reset_n low during RUN with remaining=2 -> all outputs 0 asynchronously; after release, req=1000 is granted one edge later.
REQ-039 Idle tick: no req, 12 cycles -> tick_ms pulses every 4th cycle, and busy stays 0.
